console_uart_tx: RTL and testbench
==================================

CONSOLE_UART_TX -- requirements
Module: console_uart_tx

Interface
REQ-001 SHALL have parameter CONSOLE_ADDR, default 32'h1000_0000, byte-sink address for console characters.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, character buffer entries; power of two, 2..128.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit; minimum 2.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_la_write  input  1  look-ahead write strobe from the CPU.
REQ-007 SHALL have port mem_la_read  input  1  look-ahead read strobe from the CPU.
REQ-008 SHALL have port mem_la_addr  input  32  look-ahead byte address.
REQ-009 SHALL have port mem_la_wdata  input  32  look-ahead write data.
REQ-010 SHALL have port mem_la_wstrb  input  4  look-ahead byte enables.
REQ-011 SHALL have port status_rdata  output  32  registered status word.
REQ-012 SHALL have port status_valid  output  1  status_rdata holds a status-read response this cycle.
REQ-013 SHALL have port uart_tx  output  1  serial line, idle high, registered.
REQ-014 SHALL have port busy  output  1  high while FIFO non-empty or a frame is in flight.

Function
REQ-015 SHALL accept a character on a clk edge where mem_la_write=1, mem_la_addr==CONSOLE_ADDR and mem_la_wstrb[0]=1; the character is mem_la_wdata[7:0].
REQ-016 SHALL ignore writes with wstrb[0]=0 or any other address, including CONSOLE_ADDR+4.
REQ-017 SHALL drop an accepted character when the FIFO is full as sampled before that edge, even if a pop occurs on the same edge, and increment a 16-bit overflow counter that saturates at 16'hFFFF.
REQ-018 SHALL, on a simultaneous push into a non-full FIFO and pop, keep the level unchanged and preserve order.
REQ-019 SHALL respond to mem_la_read with mem_la_addr==CONSOLE_ADDR+4 on the next edge: status_valid=1; status_rdata[7:0]=level; [8]=full; [9]=empty; [10]=tx active; [15:11]=0; [31:16]=overflow count, sampled pre-edge.
REQ-020 SHALL drive status_valid=0 and status_rdata=0 in all other cycles.
REQ-021 SHALL implement a transmitter FSM with states IDLE, START, DATA, STOP.
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and enter START on the same edge.
REQ-023 A byte pushed into an empty FIFO SHALL first drive uart_tx low two edges after the accepting edge.
REQ-024 SHALL send 8N1 frames: start bit 0, data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles.
REQ-025 At the end of STOP with the FIFO non-empty, the FSM SHALL pop and enter START directly, with no idle gap; otherwise it SHALL return to IDLE.
REQ-026 The bit-period counter SHALL be sized clog2(CLKS_PER_BIT) and the bit index 3 bits; neither SHALL wrap inside a bit or frame.
REQ-027 FIFO pointers SHALL be clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; the level SHALL be clog2(FIFO_DEPTH)+1 bits, so full reports level=FIFO_DEPTH.

Reset
REQ-028 On reset=1 at an edge, SHALL set FSM=IDLE, FIFO empty, overflow count=0, uart_tx=1, busy=0, status_valid=0, status_rdata=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately (uart_tx=1 next cycle) and discard FIFO contents.
REQ-030 Writes and reads presented while reset=1 SHALL be ignored.

Structure
REQ-031 Package console_pkg SHALL hold the default CONSOLE_ADDR, the status offset (4), status bit positions, and the FSM state enum.
REQ-032 The FIFO SHALL be a separate sub-module console_fifo (synchronous, single clock, push/pop/full/empty/level); the FSM, decode and status logic SHALL stay in console_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Write 32'h41 to 32'h1000_0000 -> uart_tx low 2 edges later, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, stop high; frame 40 cycles; busy falls after stop.
REQ-034 Six back-to-back writes 'a'..'f' -> 'a' popped, 'b'..'e' buffered, 'f' dropped; overflow count=1; 'a'..'e' sent with no inter-frame idle.
REQ-035 Status read at 32'h1000_0004 while 3 bytes are queued and a frame is active -> next cycle status_valid=1, status_rdata=32'h0000_0403.
REQ-036 Writes with wstrb=4'b0010 to CONSOLE_ADDR and 4'b0001 to 32'h1000_0008 -> no FIFO change, uart_tx stays high.
REQ-037 reset=1 during the DATA state with 2 bytes queued -> uart_tx=1 next cycle, status then reads 32'h0000_0200, no further frames.
REQ-038 Full FIFO with push and pop on the same edge -> push dropped, overflow count increments, level becomes 3.

Source files
------------

// File: rtl/console_pkg.sv
// Shared definitions for the console UART transmitter.
// Holds the default console byte-sink address, the status register offset,
// the bit positions inside the status word, and the transmitter state type.
package console_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h1000_0000;
  localparam logic [31:0] STATUS_OFFSET        = 32'd4;

  // Status word layout: [7:0] level, [8] full, [9] empty, [10] tx active,
  // [15:11] zero, [31:16] overflow count.
  localparam int STAT_LEVEL_LSB  = 0;
  localparam int STAT_FULL_BIT   = 8;
  localparam int STAT_EMPTY_BIT  = 9;
  localparam int STAT_ACTIVE_BIT = 10;
  localparam int STAT_OVF_LSB    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/console_fifo.sv
// Synchronous single-clock byte FIFO for the console transmitter.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   push, wdata     - write request and byte; ignored when full
//   pop, rdata      - read request; rdata always shows the head entry
//   full, empty     - occupancy flags
//   level           - number of stored entries (0..DEPTH)
module console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  output logic [7:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the pre-edge level, so a push into a full FIFO is
  // dropped even when a pop happens on the same edge.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; contents are only ever read
  // through rd_ptr once level says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/console_uart_tx.sv
// Memory-mapped console UART transmitter.
// A CPU look-ahead write of a byte to CONSOLE_ADDR queues a character; the
// characters are sent as 8N1 frames on uart_tx. A look-ahead read of
// CONSOLE_ADDR+4 returns a status word on the following cycle.
// Ports:
//   clk, reset             - clock and synchronous active-high reset
//   mem_la_write/read      - look-ahead write/read strobes
//   mem_la_addr/wdata/wstrb- look-ahead address, write data, byte enables
//   status_rdata/valid     - registered status response
//   uart_tx                - registered serial line, idle high
//   busy                   - characters queued or a frame on the line
module console_uart_tx
  import console_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_la_write,
  input  logic        mem_la_read,
  input  logic [31:0] mem_la_addr,
  input  logic [31:0] mem_la_wdata,
  input  logic [3:0]  mem_la_wstrb,
  output logic [31:0] status_rdata,
  output logic        status_valid,
  output logic        uart_tx,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          line_busy;

  logic          accept;
  logic          status_hit;
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [15:0]   ovf_cnt;
  logic          bit_last;
  logic          tx_active;
  logic [31:0]   status_word;

  // Only byte lane 0 carries the character.
  logic unused_bits;
  assign unused_bits = &{1'b0, mem_la_wdata[31:8], mem_la_wstrb[3:1]};

  assign accept     = mem_la_write && (mem_la_addr == CONSOLE_ADDR) && mem_la_wstrb[0];
  assign status_hit = mem_la_read && (mem_la_addr == CONSOLE_ADDR + STATUS_OFFSET);
  assign bit_last   = (bit_cnt == CNT_LAST);

  // Pop when leaving IDLE or at the end of a stop bit, so back-to-back
  // characters go out with no idle gap between frames.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) || ((state == STOP) && bit_last));

  // uart_tx lags the state by one register, so the line is still busy for
  // one cycle after the FSM returns to IDLE.
  assign tx_active = (state != IDLE) || line_busy;
  assign busy      = !fifo_empty || tx_active;

  console_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (mem_la_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_LEVEL_LSB +: 8]  = 8'(fifo_level);
    status_word[STAT_FULL_BIT]        = fifo_full;
    status_word[STAT_EMPTY_BIT]       = fifo_empty;
    status_word[STAT_ACTIVE_BIT]      = tx_active;
    status_word[STAT_OVF_LSB +: 16]   = ovf_cnt;
  end

  // Overflow counter and status response.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt      <= '0;
      status_valid <= 1'b0;
      status_rdata <= '0;
    end else begin
      if (accept && fifo_full && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 1'b1;
      status_valid <= status_hit;
      status_rdata <= status_hit ? status_word : '0;
    end
  end

  // Transmitter FSM; the line register encodes the bit of the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      uart_tx   <= 1'b1;
      line_busy <= 1'b0;
    end else begin
      line_busy <= (state != IDLE);
      case (state)
        START:   uart_tx <= 1'b0;
        DATA:    uart_tx <= shreg[0];
        default: uart_tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!fifo_empty) begin
            shreg <= fifo_rdata;
            state <= START;
          end
        end
        START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (!fifo_empty) begin
              shreg <= fifo_rdata;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_console_uart_tx.sv
// Self-checking bench for console_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Expected characters are queued when written and compared as a serial
// monitor decodes frames from uart_tx.
module tb_console_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] CADDR = 32'h1000_0000;
  localparam logic [31:0] SADDR = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_la_write;
  logic        mem_la_read;
  logic [31:0] mem_la_addr;
  logic [31:0] mem_la_wdata;
  logic [3:0]  mem_la_wstrb;
  logic [31:0] status_rdata;
  logic        status_valid;
  logic        uart_tx;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc;

  logic [7:0] exp_q[$];
  int         starts[$];

  bit         mon_en = 1'b1;
  bit         m_active = 1'b0;
  int         m_cnt;
  logic [7:0] m_byte;

  console_uart_tx #(
    .CONSOLE_ADDR (CADDR),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_la_write (mem_la_write),
    .mem_la_read  (mem_la_read),
    .mem_la_addr  (mem_la_addr),
    .mem_la_wdata (mem_la_wdata),
    .mem_la_wstrb (mem_la_wstrb),
    .status_rdata (status_rdata),
    .status_valid (status_valid),
    .uart_tx      (uart_tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Serial monitor: samples the middle of each bit, compares against the queue.
  always @(negedge clk) begin
    if (!mon_en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (uart_tx == 1'b0) begin
        m_active = 1'b1;
        m_cnt    = 0;
        starts.push_back(cyc);
      end
    end else begin
      m_cnt++;
      if (m_cnt % CPB == CPB / 2) begin
        int k;
        k = m_cnt / CPB;
        if (k == 0) begin
          check("rx_start_bit", uart_tx, 1'b0);
        end else if (k <= 8) begin
          m_byte[k-1] = uart_tx;
        end else begin
          check("rx_stop_bit", uart_tx, 1'b1);
          check("rx_queue_nonempty", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("rx_byte", m_byte, exp_q.pop_front());
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic cpu_write(input logic [31:0] addr, input logic [7:0] data,
                           input logic [3:0] strb, input bit expect_accept);
    mem_la_write = 1'b1;
    mem_la_addr  = addr;
    mem_la_wdata = {24'hABCDEF, data};
    mem_la_wstrb = strb;
    @(posedge clk); #1;
    if (expect_accept) exp_q.push_back(data);
    last_acc     = cyc;
    mem_la_write = 1'b0;
    mem_la_addr  = '0;
    mem_la_wdata = '0;
    mem_la_wstrb = '0;
  endtask

  task automatic status_read(input string tag, input logic [31:0] exp);
    check("stat_idle_valid", status_valid, 1'b0);
    check("stat_idle_data", status_rdata, 32'h0);
    mem_la_read = 1'b1;
    mem_la_addr = SADDR;
    @(posedge clk); #1;
    mem_la_read = 1'b0;
    mem_la_addr = '0;
    check("stat_valid", status_valid, 1'b1);
    check(tag, status_rdata, exp);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_active) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lows;
    logic [7:0] ch;
    logic       exp_tx;

    reset        = 1'b1;
    mem_la_write = 1'b0;
    mem_la_read  = 1'b0;
    mem_la_addr  = '0;
    mem_la_wdata = '0;
    mem_la_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_status_valid", status_valid, 1'b0);
    check("rst_status_rdata", status_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    status_read("stat_after_reset", 32'h0000_0200);

    // Single character 'A': exact line waveform and busy timing.
    ch = 8'h41;
    starts.delete();
    cpu_write(CADDR, ch, 4'b0001, 1'b1);
    for (int k = 0; k <= 42; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 5)       exp_tx = 1'b0;
      else if (k >= 6 && k <= 37) exp_tx = ch[(k - 6) / 4];
      else                        exp_tx = 1'b1;
      check($sformatf("wave_tx_%0d", k), uart_tx, exp_tx);
      check($sformatf("wave_busy_%0d", k), busy, (k <= 41) ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1;
    wait_drain(200);
    check("start_latency", starts.size() > 0 ? starts[0] - last_acc : -1, 2);

    // Three queued behind an active frame, no overflow yet.
    cpu_write(CADDR, 8'h31, 4'b0001, 1'b1);
    cpu_write(CADDR, 8'h32, 4'b0001, 1'b1);
    cpu_write(CADDR, 8'h33, 4'b0001, 1'b1);
    cpu_write(CADDR, 8'h34, 4'b1111, 1'b1);
    status_read("stat_three_queued", 32'h0000_0403);
    wait_drain(400);

    // Six back-to-back writes: 'f' dropped; then a push into a full FIFO
    // on the exact edge the FSM pops 'b'.
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      cpu_write(CADDR, 8'h61 + 8'(i), 4'b0001, i < 5);
      if (i == 0) m_cnt = m_cnt; // keep alignment; first write edge is Ea
    end
    status_read("stat_full_ovf1", 32'h0001_0504);
    repeat (34) @(posedge clk);
    #1;
    cpu_write(CADDR, 8'h78, 4'b0001, 1'b0);
    status_read("stat_push_pop_full", 32'h0002_0403);
    wait_drain(600);
    check("gapless_frames", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++)
      check($sformatf("frame_gap_%0d", i), starts[i] - starts[i-1], 10 * CPB);

    // Writes that must be ignored.
    cpu_write(CADDR, 8'h55, 4'b0010, 1'b0);
    cpu_write(CADDR + 32'd8, 8'h56, 4'b0001, 1'b0);
    cpu_write(SADDR, 8'h57, 4'b0001, 1'b0);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx == 1'b0) lows++;
    end
    @(posedge clk); #1;
    check("ignored_writes_line_idle", lows, 0);
    check("ignored_writes_busy", busy, 1'b0);
    status_read("stat_ignored_writes", 32'h0002_0200);

    // Reset in the middle of DATA with two bytes queued.
    cpu_write(CADDR, 8'h70, 4'b0001, 1'b1);
    cpu_write(CADDR, 8'h71, 4'b0001, 1'b1);
    cpu_write(CADDR, 8'h72, 4'b0001, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    mon_en       = 1'b0;
    reset        = 1'b1;
    mem_la_write = 1'b1;
    mem_la_wstrb = 4'b0001;
    mem_la_wdata = 32'h5A;
    mem_la_addr  = CADDR;
    @(posedge clk); #1;
    check("abort_uart_tx", uart_tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_status_valid", status_valid, 1'b0);
    mem_la_write = 1'b0;
    mem_la_read  = 1'b1;
    mem_la_addr  = SADDR;
    @(posedge clk); #1;
    check("reset_read_ignored", status_valid, 1'b0);
    mem_la_read  = 1'b0;
    mem_la_addr  = '0;
    mem_la_wdata = '0;
    mem_la_wstrb = '0;
    reset        = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    status_read("stat_after_abort", 32'h0000_0200);
    mon_en = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx == 1'b0) lows++;
    end
    @(posedge clk); #1;
    check("no_frames_after_abort", lows, 0);
    check("busy_after_abort", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
